// File: rtl/csr_pkg.sv
// Shared constants, state encoding and SYSTEM-opcode decode for the CSR/trap sequencer.
package csr_pkg;

  localparam int unsigned CSR_AW = 12;
  localparam int unsigned REG_AW = 5;

  localparam logic [CSR_AW-1:0] MSTATUS = 12'h300;
  localparam logic [CSR_AW-1:0] MTVEC   = 12'h305;
  localparam logic [CSR_AW-1:0] MEPC    = 12'h341;
  localparam logic [CSR_AW-1:0] MCAUSE  = 12'h342;

  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_PRIV = 3'b000;
  localparam logic [2:0] F3_RW   = 3'b001;
  localparam logic [2:0] F3_RS   = 3'b010;
  localparam logic [2:0] F3_RC   = 3'b011;
  localparam logic [2:0] F3_RSV  = 3'b100;
  localparam logic [2:0] F3_RWI  = 3'b101;
  localparam logic [2:0] F3_RSI  = 3'b110;
  localparam logic [2:0] F3_RCI  = 3'b111;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    IDLE, READ, WRITE, EPC, CAUSE, VEC, MRET_RD, DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_CSR, OP_ECALL, OP_MRET, OP_EBREAK, OP_ILLEGAL
  } sys_op_e;

  // Instruction fields still needed after the accept cycle
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [2:0]        funct3;
  } csr_fields_t;

  function automatic sys_op_e decode_op(input logic [31:0] inst);
    sys_op_e op;
    op = OP_ILLEGAL;
    if (inst == INST_ECALL)
      op = OP_ECALL;
    else if (inst == INST_MRET)
      op = OP_MRET;
    else if (inst == INST_EBREAK)
      op = OP_EBREAK;
    else if (inst[6:0] == OPC_SYSTEM && inst[14:12] != F3_PRIV && inst[14:12] != F3_RSV)
      op = OP_CSR;
    return op;
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Read-modify-write datapath for Zicsr ops: new CSR value and whether to write it.
module csr_alu #(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] old_val,
  input  logic [XLEN-1:0] src_val,
  input  logic [4:0]      rs1_field,
  output logic [XLEN-1:0] new_c,
  output logic            do_write_c
);

  // op is funct3[1:0]: 01 swap, 10 set, 11 clear; register and immediate forms share it
  always_comb begin
    new_c      = src_val;
    do_write_c = 1'b1;
    case (op)
      2'b10: begin
        new_c      = old_val | src_val;
        do_write_c = (rs1_field != 5'd0);
      end
      2'b11: begin
        new_c      = old_val & ~src_val;
        do_write_c = (rs1_field != 5'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Sequencer between the core and the CSR file: Zicsr read-modify-write plus ecall/mret/ebreak flows.
module csr_trap_ctrl
  import csr_pkg::*;
#(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] MCAUSE_ECALL = XLEN'(32'hb)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  output logic [CSR_AW-1:0] csr_addr,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              csr_wen,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rd_wen,
  output logic [REG_AW-1:0] rd_addr,
  output logic [XLEN-1:0]   rd_wdata,
  output logic              redirect_valid,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              ebreak,
  output logic              illegal
);

  state_e            state_q, state_d;
  csr_fields_t       fields_q, fields_d;
  logic [XLEN-1:0]   src_q, src_d;

  logic              in_ready_d;
  logic [CSR_AW-1:0] csr_addr_d;
  logic [XLEN-1:0]   csr_wdata_d;
  logic              csr_wen_d;
  logic              out_valid_d;
  logic              rd_wen_d;
  logic [REG_AW-1:0] rd_addr_d;
  logic [XLEN-1:0]   rd_wdata_d;
  logic              redirect_valid_d;
  logic [XLEN-1:0]   redirect_pc_d;
  logic              ebreak_d;
  logic              illegal_d;

  logic [XLEN-1:0]   alu_new_c;
  logic              alu_do_write_c;

  csr_alu #(.XLEN(XLEN)) u_alu (
    .op         (fields_q.funct3[1:0]),
    .old_val    (csr_rdata),
    .src_val    (src_q),
    .rs1_field  (fields_q.rs1),
    .new_c      (alu_new_c),
    .do_write_c (alu_do_write_c)
  );

  // Next-state and next-output logic; every output is registered, so CSR pins lead the state by one edge
  always_comb begin
    state_d          = state_q;
    fields_d         = fields_q;
    src_d            = src_q;
    csr_addr_d       = csr_addr;
    csr_wdata_d      = csr_wdata;
    csr_wen_d        = 1'b0;
    out_valid_d      = out_valid;
    rd_wen_d         = rd_wen;
    rd_addr_d        = rd_addr;
    rd_wdata_d       = rd_wdata;
    redirect_valid_d = redirect_valid;
    redirect_pc_d    = redirect_pc;
    ebreak_d         = ebreak;
    illegal_d        = illegal;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          fields_d.rd     = inst[11:7];
          fields_d.rs1    = inst[19:15];
          fields_d.funct3 = inst[14:12];
          src_d           = inst[14] ? XLEN'(inst[19:15]) : rs1_data;
          case (decode_op(inst))
            OP_CSR: begin
              state_d    = READ;
              csr_addr_d = inst[31:20];
            end
            OP_ECALL: begin
              state_d     = EPC;
              csr_addr_d  = MEPC;
              csr_wdata_d = pc;
              csr_wen_d   = 1'b1;
            end
            OP_MRET: begin
              state_d    = MRET_RD;
              csr_addr_d = MEPC;
            end
            OP_EBREAK: begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              ebreak_d    = 1'b1;
            end
            default: begin
              state_d     = DONE;
              out_valid_d = 1'b1;
              illegal_d   = 1'b1;
            end
          endcase
        end
      end
      READ: begin
        state_d     = WRITE;
        csr_wdata_d = alu_new_c;
        csr_wen_d   = alu_do_write_c;
        rd_addr_d   = fields_q.rd;
        rd_wdata_d  = csr_rdata;
      end
      WRITE: begin
        state_d     = DONE;
        out_valid_d = 1'b1;
        rd_wen_d    = (fields_q.rd != '0);
      end
      EPC: begin
        state_d     = CAUSE;
        csr_addr_d  = MCAUSE;
        csr_wdata_d = MCAUSE_ECALL;
        csr_wen_d   = 1'b1;
      end
      CAUSE: begin
        state_d    = VEC;
        csr_addr_d = MTVEC;
      end
      VEC: begin
        state_d          = DONE;
        out_valid_d      = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = {csr_rdata[XLEN-1:2], 2'b00};
      end
      MRET_RD: begin
        state_d          = DONE;
        out_valid_d      = 1'b1;
        redirect_valid_d = 1'b1;
        redirect_pc_d    = csr_rdata;
      end
      DONE: begin
        if (out_ready) begin
          state_d          = IDLE;
          out_valid_d      = 1'b0;
          rd_wen_d         = 1'b0;
          redirect_valid_d = 1'b0;
          ebreak_d         = 1'b0;
          illegal_d        = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      fields_q       <= '0;
      src_q          <= '0;
      in_ready       <= 1'b1;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      csr_wen        <= 1'b0;
      out_valid      <= 1'b0;
      rd_wen         <= 1'b0;
      rd_addr        <= '0;
      rd_wdata       <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      ebreak         <= 1'b0;
      illegal        <= 1'b0;
    end else begin
      state_q        <= state_d;
      fields_q       <= fields_d;
      src_q          <= src_d;
      in_ready       <= in_ready_d;
      csr_addr       <= csr_addr_d;
      csr_wdata      <= csr_wdata_d;
      csr_wen        <= csr_wen_d;
      out_valid      <= out_valid_d;
      rd_wen         <= rd_wen_d;
      rd_addr        <= rd_addr_d;
      rd_wdata       <= rd_wdata_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
      ebreak         <= ebreak_d;
      illegal        <= illegal_d;
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: CSR-file stand-in plus a transaction-level model of each SYSTEM instruction.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] inst = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        csr_wen;
  logic [31:0] csr_rdata;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ebreak;
  logic        illegal;

  always #5 clk = ~clk;

  csr_trap_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
    .rs1_data(rs1_data), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_wen(csr_wen),
    .csr_rdata(csr_rdata), .out_valid(out_valid), .out_ready(out_ready), .rd_wen(rd_wen),
    .rd_addr(rd_addr), .rd_wdata(rd_wdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ebreak(ebreak), .illegal(illegal)
  );

  // One retired instruction as seen at the core/CSR-file boundary
  typedef struct packed {
    logic [3:0]  lat;
    logic [3:0]  gap;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        redir;
    logic [31:0] rpc;
    logic        ebrk;
    logic        ill;
    logic [2:0]  nwr;
    logic [3:0]  w0c;
    logic [11:0] w0a;
    logic [31:0] w0d;
    logic [3:0]  w1c;
    logic [11:0] w1a;
    logic [31:0] w1d;
    logic [3:0]  hold_bad;
    logic [1:0]  post;
    logic [1:0]  dup;
  } res_t;

  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_csr [0:4095];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_hs = 0;

  function automatic bit impl(input logic [11:0] a);
    return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (csr_wen && impl(csr_addr)) csr_mem[csr_addr] <= csr_wdata;
  assign csr_rdata = impl(csr_addr) ? csr_mem[csr_addr] : 32'h0;

  function automatic logic [31:0] enc(input logic [11:0] a, input logic [4:0] s,
                                      input logic [2:0] f, input logic [4:0] d);
    return {a, s, f, d, 7'h73};
  endfunction

  function automatic bit is_csr_op(input logic [31:0] i);
    return i[6:0] == 7'h73 && i[14:12] != 3'd0 && i[14:12] != 3'd4;
  endfunction

  // Expected result of one instruction from the ISA rules and the model's CSR contents
  function automatic res_t predict(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r);
    res_t e;
    logic [31:0] old, src, nv;
    logic [2:0] f3;
    e = '0;
    e.gap = 4'd1;
    e.post = 2'b01;
    if (i == 32'h0000_0073) begin
      e.lat = 4'd4; e.nwr = 3'd2;
      e.w0c = 4'd1; e.w0a = 12'h341; e.w0d = p;
      e.w1c = 4'd2; e.w1a = 12'h342; e.w1d = 32'hb;
      e.redir = 1'b1; e.rpc = ref_csr[12'h305] & 32'hFFFF_FFFC;
    end else if (i == 32'h3020_0073) begin
      e.lat = 4'd2; e.redir = 1'b1; e.rpc = ref_csr[12'h341];
    end else if (i == 32'h0010_0073) begin
      e.lat = 4'd1; e.ebrk = 1'b1;
    end else if (is_csr_op(i)) begin
      f3  = i[14:12];
      src = f3[2] ? {27'd0, i[19:15]} : r;
      old = impl(i[31:20]) ? ref_csr[i[31:20]] : 32'h0;
      case (f3[1:0])
        2'd1:    nv = src;
        2'd2:    nv = old | src;
        default: nv = old & ~src;
      endcase
      e.lat = 4'd3; e.rd_addr = i[11:7]; e.rd_wdata = old; e.rd_wen = (i[11:7] != 5'd0);
      if (f3[1:0] == 2'd1 || i[19:15] != 5'd0) begin
        e.nwr = 3'd1; e.w0c = 4'd2; e.w0a = i[31:20]; e.w0d = nv;
      end
    end else begin
      e.lat = 4'd1; e.ill = 1'b1;
    end
    return e;
  endfunction

  task automatic apply(input res_t e);
    if (e.nwr >= 3'd1 && impl(e.w0a)) ref_csr[e.w0a] = e.w0d;
    if (e.nwr >= 3'd2 && impl(e.w1a)) ref_csr[e.w1a] = e.w1d;
  endtask

  task automatic set_csr(input logic [11:0] a, input logic [31:0] v);
    csr_mem[a] = v;
    ref_csr[a] = v;
  endtask

  // Drive one instruction and observe it to the handshake; entered and left at a negedge
  task automatic issue(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r,
                       input int hold, output res_t o);
    int acc;
    int n;
    logic prev_w;
    logic [11:0] prev_a;
    logic [75:0] snap;
    o = '0;
    in_valid = 1'b1; inst = i; pc = p; rs1_data = r;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) begin in_valid = 1'b0; o.lat = 4'hF; return; end
    acc = cyc;
    o.gap = 4'(acc - last_hs);
    prev_w = 1'b0; prev_a = '0;
    @(negedge clk);
    in_valid = 1'b0; inst = $urandom; pc = $urandom; rs1_data = $urandom;
    for (n = 0; n < 12; n++) begin
      if (csr_wen) begin
        if (prev_w && csr_addr == prev_a) o.dup = o.dup + 2'd1;
        if (o.nwr == 3'd0) begin o.w0c = 4'(cyc - acc); o.w0a = csr_addr; o.w0d = csr_wdata; end
        else if (o.nwr == 3'd1) begin o.w1c = 4'(cyc - acc); o.w1a = csr_addr; o.w1d = csr_wdata; end
        if (o.nwr != 3'd7) o.nwr = o.nwr + 3'd1;
      end
      prev_w = csr_wen; prev_a = csr_addr;
      if (out_valid) break;
      @(negedge clk);
    end
    if (!out_valid) begin o.lat = 4'hF; return; end
    o.lat = 4'(cyc - acc);
    o.rd_wen = rd_wen; o.rd_addr = rd_addr; o.rd_wdata = rd_wdata;
    o.redir = redirect_valid; o.rpc = redirect_pc; o.ebrk = ebreak; o.ill = illegal;
    snap = {rd_wen, rd_addr, rd_wdata, redirect_valid, redirect_pc, ebreak, illegal, in_ready, csr_wen};
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (csr_wen && o.nwr != 3'd7) o.nwr = o.nwr + 3'd1;
      if ({rd_wen, rd_addr, rd_wdata, redirect_valid, redirect_pc, ebreak, illegal, in_ready, csr_wen} !== snap
          || out_valid !== 1'b1 || in_ready !== 1'b0)
        o.hold_bad = o.hold_bad + 4'd1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (csr_wen && o.nwr != 3'd7) o.nwr = o.nwr + 3'd1;
    o.post = {out_valid, in_ready};
    last_hs = cyc - 1;
    if (!is_csr_op(i)) begin o.rd_addr = '0; o.rd_wdata = '0; end
    if (!o.redir) o.rpc = '0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({out_valid, rd_wen, redirect_valid, ebreak, illegal, csr_wen, csr_addr, csr_wdata,
         rd_addr, rd_wdata, redirect_pc} !== '0)
      begin bad++; $display("FAIL reset_outputs: got ov=%b wen=%b addr=%h rdw=%h rpc=%h want all zero",
                            out_valid, csr_wen, csr_addr, rd_wdata, redirect_pc); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || csr_wen !== 1'b0)
      begin bad++; $display("FAIL reset_release: got in_ready=%b out_valid=%b csr_wen=%b want 1 0 0",
                            in_ready, out_valid, csr_wen); end
    last_hs = cyc - 1;
  endtask

  task automatic test_csrrw();
    res_t o, e;
    logic [31:0] i;
    set_csr(12'h305, 32'h8000_0000);
    i = enc(12'h305, 5'd10, 3'b001, 5'd5);
    e = predict(i, 32'h100, 32'h8000_0100);
    issue(i, 32'h100, 32'h8000_0100, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL csrrw: got %h want %h", o, e); end
    total++;
    if (o.w0d !== 32'h8000_0100 || o.w0c !== 4'd2 || o.rd_wdata !== 32'h8000_0000 || o.rd_addr !== 5'd5)
      begin bad++; $display("FAIL csrrw_literal: got w=%h@%0d rd=x%0d=%h want 80000100@2 x5=80000000",
                            o.w0d, o.w0c, o.rd_addr, o.rd_wdata); end
    apply(e);
  endtask

  task automatic test_csrrs();
    res_t o, e;
    logic [31:0] i;
    set_csr(12'h341, 32'h1234);
    i = enc(12'h341, 5'd0, 3'b010, 5'd6);
    e = predict(i, 32'h104, 32'hFFFF_FFFF);
    issue(i, 32'h104, 32'hFFFF_FFFF, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL csrrs_x0: got %h want %h", o, e); end
    total++;
    if (o.nwr !== 3'd0 || o.rd_wdata !== 32'h1234)
      begin bad++; $display("FAIL csrrs_x0_literal: got writes=%0d rd=%h want 0 1234", o.nwr, o.rd_wdata); end
    apply(e);
    i = enc(12'h341, 5'd11, 3'b010, 5'd6);
    e = predict(i, 32'h108, 32'hF0);
    issue(i, 32'h108, 32'hF0, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL csrrs: got %h want %h", o, e); end
    total++;
    if (o.w0d !== 32'h12F4) begin bad++; $display("FAIL csrrs_literal: got %h want 12f4", o.w0d); end
    apply(e);
  endtask

  task automatic test_csrrci();
    res_t o, e;
    logic [31:0] i;
    set_csr(12'h341, 32'h1F);
    i = enc(12'h341, 5'd4, 3'b111, 5'd7);
    e = predict(i, 32'h10C, 32'hFFFF_FFFF);
    issue(i, 32'h10C, 32'hFFFF_FFFF, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL csrrci: got %h want %h", o, e); end
    total++;
    if (o.w0d !== 32'h1B || o.rd_wdata !== 32'h1F)
      begin bad++; $display("FAIL csrrci_literal: got w=%h rd=%h want 1b 1f", o.w0d, o.rd_wdata); end
    apply(e);
  endtask

  task automatic test_ecall_mret();
    res_t o, e;
    set_csr(12'h305, 32'h8000_0200);
    e = predict(32'h73, 32'h8000_0040, 32'h0);
    issue(32'h73, 32'h8000_0040, 32'h0, 0, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL ecall: got %h want %h", o, e); end
    total++;
    if (o.rpc !== 32'h8000_0200 || o.lat !== 4'd4)
      begin bad++; $display("FAIL ecall_literal: got pc=%h lat=%0d want 80000200 4", o.rpc, o.lat); end
    apply(e);
    e = predict(32'h3020_0073, 32'h8000_0200, 32'h0);
    issue(32'h3020_0073, 32'h8000_0200, 32'h0, 3, o);
    total++;
    if (o !== e) begin bad++; $display("FAIL mret_hold: got %h want %h", o, e); end
    total++;
    if (o.rpc !== 32'h8000_0040 || o.lat !== 4'd2)
      begin bad++; $display("FAIL mret_literal: got pc=%h lat=%0d want 80000040 2", o.rpc, o.lat); end
    apply(e);
  endtask

  task automatic test_reset_mid();
    set_csr(12'h342, 32'h5A5A);
    in_valid = 1'b1; inst = 32'h73; pc = 32'h8000_0080;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (csr_wen !== 1'b1 || csr_addr !== 12'h342)
      begin bad++; $display("FAIL rst_mid_cause: got wen=%b addr=%h want 1 342", csr_wen, csr_addr); end
    rst = 1'b1;
    #1;
    total++;
    if (csr_wen !== 1'b0 || out_valid !== 1'b0)
      begin bad++; $display("FAIL rst_mid_abort: got wen=%b ov=%b want 0 0", csr_wen, out_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_csr[12'h341] = 32'h8000_0080;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if ({csr_wen, out_valid, in_ready} !== 3'b001)
        begin bad++; $display("FAIL rst_mid_after: got wen/ov/rdy=%b want 001", {csr_wen, out_valid, in_ready}); end
    end
    total++;
    if (csr_mem[12'h341] !== ref_csr[12'h341] || csr_mem[12'h342] !== ref_csr[12'h342])
      begin bad++; $display("FAIL rst_mid_csrs: got mepc=%h mcause=%h want %h %h",
                            csr_mem[12'h341], csr_mem[12'h342], ref_csr[12'h341], ref_csr[12'h342]); end
    last_hs = cyc - 1;
  endtask

  task automatic test_illegal();
    res_t o, e;
    logic [31:0] list [4];
    list[0] = 32'h0020_0073;
    list[1] = 32'h0010_0073;
    list[2] = enc(12'h305, 5'd3, 3'b100, 5'd4);
    list[3] = {12'h305, 5'd3, 3'b001, 5'd4, 7'h33};
    for (int k = 0; k < 4; k++) begin
      e = predict(list[k], 32'h200, 32'h55);
      issue(list[k], 32'h200, 32'h55, k % 2, o);
      total++;
      if (o !== e) begin bad++; $display("FAIL illegal_ebreak[%0d]: got %h want %h", k, o, e); end
      apply(e);
    end
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    logic [31:0] i, r;
    for (int k = 0; k < 6; k++) begin
      i = enc(12'h340, 5'(k + 1), 3'b001 + 3'(k % 3), 5'(k + 8));
      r = $urandom;
      e = predict(i, 32'h300, r);
      issue(i, 32'h300, r, 0, o);
      total++;
      if (o !== e) begin bad++; $display("FAIL back_to_back[%0d]: got %h want %h", k, o, e); end
      apply(e);
    end
  endtask

  task automatic test_random();
    res_t o, e;
    logic [31:0] i, p, r;
    logic [11:0] a;
    int kind;
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 9);
      p = $urandom & 32'hFFFF_FFFC;
      r = $urandom;
      case ($urandom_range(0, 7))
        0: a = 12'h300; 1: a = 12'h305; 2: a = 12'h340; 3: a = 12'h341;
        4: a = 12'h342; 5: a = 12'h7C0; 6: a = 12'hF11; default: a = 12'hB00;
      endcase
      if (kind < 7)
        i = enc(a, ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                {1'($urandom_range(0, 1)), 2'($urandom_range(1, 3))}, 5'($urandom_range(0, 31)));
      else if (kind == 7) i = 32'h0000_0073;
      else if (kind == 8) i = 32'h3020_0073;
      else begin
        i = $urandom;
        if (i[0]) i = 32'h0010_0073;
      end
      e = predict(i, p, r);
      issue(i, p, r, $urandom_range(0, 2), o);
      total++;
      if (o !== e) begin bad++; $display("FAIL random[%0d] inst=%h: got %h want %h", k, i, o, e); end
      apply(e);
    end
    total++;
    if (csr_mem[12'h300] !== ref_csr[12'h300] || csr_mem[12'h305] !== ref_csr[12'h305] ||
        csr_mem[12'h340] !== ref_csr[12'h340] || csr_mem[12'h341] !== ref_csr[12'h341] ||
        csr_mem[12'h342] !== ref_csr[12'h342])
      begin bad++; $display("FAIL csr_state: got mtvec=%h mepc=%h mcause=%h want %h %h %h",
                            csr_mem[12'h305], csr_mem[12'h341], csr_mem[12'h342],
                            ref_csr[12'h305], ref_csr[12'h341], ref_csr[12'h342]); end
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) begin csr_mem[a] = '0; ref_csr[a] = '0; end
    set_csr(12'h300, 32'h0000_1800);
    test_reset();
    test_csrrw();
    test_csrrs();
    test_csrrci();
    test_ecall_mret();
    test_reset_mid();
    test_illegal();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
